ofs_plat_avalon_mem_rdwr_sink_ram: RTL and testbench
====================================================

# ofs_plat_avalon_mem_rdwr_sink_ram

RAM-backed responder for the split read/write Avalon memory protocol. It sits at the sink end of an `ofs_plat_avalon_mem_rdwr_if` chain, after any skid or register stages, and answers read and write bursts from a local memory. It serves as a behavioural memory endpoint for simulation and on-chip loopback, and it generates exactly the response traffic that upstream sources and response registers consume.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: word (line) address width.
- `DATA_WIDTH`, 64: data width in bits. Must be a multiple of 8.
- `BURST_CNT_WIDTH`, 4: burstcount width.
- `USER_WIDTH`, 4: request/response user width.
- `RAM_ADDR_BITS`, 8: log2 of the RAM depth in words. Must be ≤ `ADDR_WIDTH`.

Ports (`DATA_N_BYTES` = `DATA_WIDTH`/8):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_read`  in  1  read request valid.
- `rd_address`  in  `ADDR_WIDTH`  burst start word address.
- `rd_burstcount`  in  `BURST_CNT_WIDTH`  beats.
- `rd_byteenable`  in  `DATA_N_BYTES`  ignored.
- `rd_user`  in  `USER_WIDTH`  echoed on every read beat.
- `rd_waitrequest`  out  1  read back-pressure.
- `rd_readdata`  out  `DATA_WIDTH`  read beat data.
- `rd_readdatavalid`  out  1  read beat valid.
- `rd_response`  out  2  always 0 (OKAY).
- `rd_readresponseuser`  out  `USER_WIDTH`  copy of the burst's `rd_user`.
- `wr_write`  in  1  write beat valid.
- `wr_address`  in  `ADDR_WIDTH`  start address; sampled on the first beat only.
- `wr_burstcount`  in  `BURST_CNT_WIDTH`  beats; sampled on the first beat only.
- `wr_writedata`  in  `DATA_WIDTH`  beat data.
- `wr_byteenable`  in  `DATA_N_BYTES`  per-beat byte mask.
- `wr_user`  in  `USER_WIDTH`  sampled on the first beat.
- `wr_waitrequest`  out  1  write back-pressure. Held at 0 after reset.
- `wr_writeresponsevalid`  out  1  one pulse per completed write burst.
- `wr_response`  out  2  always 0.
- `wr_writeresponseuser`  out  `USER_WIDTH`  first-beat `wr_user`.

## Operation
- RAM index = low `RAM_ADDR_BITS` of (start address + beat index). Addresses wrap modulo the RAM depth. Upper address bits are ignored.
- `burstcount` 0 is treated as 1 beat.
- Read FSM (`RD_IDLE`, `RD_BURST`):
  - A read is accepted when `rd_read && !rd_waitrequest`. On acceptance the FSM captures address, count and user, then moves to `RD_BURST`.
  - In `RD_BURST` it issues one RAM read per cycle, decrementing `beats_left`.
  - After the final issue it returns to `RD_IDLE`, or reloads directly if a new request is accepted in that same cycle.
- Read back-pressure: `rd_waitrequest` = `RD_BURST && beats_left != 1`. It is driven from registers only.
- Write path:
  - Beat counter `wr_beat` is 0 at burst start.
  - On the first beat, capture address, count and user.
  - Each accepted beat writes `wr_writedata` under `wr_byteenable` to RAM[start + `wr_beat`].
  - The final beat clears the counter and arms the response.
- Read and write of the same RAM word on the same edge: the read returns the old data.
- Reads and writes are fully independent. There is no ordering between the two channels.

## Timing
- Reset values:
  - `rd_waitrequest` = 1 while `reset` is asserted and 0 on the first cycle after release.
  - `rd_readdatavalid` = 0, `wr_writeresponsevalid` = 0.
  - FSM in `RD_IDLE`, `wr_beat` = 0.
  - `rd_readdata` and `rd_readresponseuser` are don't-care while valid is 0.
  - RAM contents are not reset.
- Read latency: request accepted at cycle T → beat i is valid at T+2+i. Beats are contiguous.
- Back-to-back read bursts: the next request is accepted in the cycle of the previous final issue, so there are no bubbles between bursts.
- Write response: final beat accepted at T → `wr_writeresponsevalid` is high for exactly T+1. Back-to-back single-beat bursts give a response every cycle.
- Responses have no flow control. The downstream side must always accept them.
- Reset asserted mid-burst: in-flight read beats and pending write responses are dropped, and both channels restart idle. Partially written RAM words remain.

## Structure
- Package `ofs_plat_avalon_mem_rdwr_sink_ram_pkg` holds:
  - `t_rd_state` enum {`RD_IDLE`, `RD_BURST`}.
  - `RSP_OKAY` = 2'b00.
- Sub-module `ofs_plat_avalon_mem_rdwr_sink_ram_bank`:
  - Simple dual-port RAM: one write port with byte enables and one registered read port.
  - Old-data read-during-write behaviour.
  - No reset.

## Test plan
- Single-beat write of 0x1122334455667788 to address 0x05 with user 3 → response pulse one cycle later carrying user 3. A read of 0x05 with user 9 then returns that data 2 cycles after acceptance, with user 9.
- 4-beat write to 0x10 with data 0xA0..0xA3 → one response only. A 4-beat read of 0x10 → 4 contiguous beats 0xA0..0xA3, and `rd_waitrequest` is high for exactly 3 cycles.
- Write 0xFF..FF to 0x20, then write 0x00..00 with byteenable 0x0F → reading 0x20 returns 0xFFFFFFFF00000000.
- 2-beat write to 0xFF with `RAM_ADDR_BITS`=8 → data lands at 0xFF and 0x00. A 2-beat read from 0xFF returns it in order.
- Read accepted at the same edge as a write to the same word → the read returns the old value, and a later read returns the new value.
- Assert `reset` during beat 2 of an 8-beat read → no further `rd_readdatavalid`. `rd_waitrequest` is 0 one cycle after release, and a new read completes normally.

Source files
------------

// File: rtl/ofs_plat_avalon_mem_rdwr_sink_ram_pkg.sv
// Shared types and constants for the split read/write Avalon RAM sink.
package ofs_plat_avalon_mem_rdwr_sink_ram_pkg;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } t_rd_state;

    localparam logic [1:0] RSP_OKAY = 2'b00;

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_sink_ram_bank.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, no reset.
// Latency: read data one cycle after rd_en; a same-edge write returns the old word.
// Backpressure: none, both ports accept every cycle.
module ofs_plat_avalon_mem_rdwr_sink_ram_bank
    import ofs_plat_avalon_mem_rdwr_sink_ram_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 64,
    localparam int N_BYTES   = DATA_WIDTH / 8
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [N_BYTES-1:0]    wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_BITS) - 1];

    // Nonblocking update gives old-data read-during-write on the same word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_sink_ram.sv
// RAM-backed responder answering split read/write Avalon bursts from a local memory.
// Latency: read beat i at accept+2+i; write response one cycle after the final beat.
// Backpressure: rd_waitrequest holds off new reads until the last beat issues; writes never stall.
module ofs_plat_avalon_mem_rdwr_sink_ram
    import ofs_plat_avalon_mem_rdwr_sink_ram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4,
    parameter int USER_WIDTH      = 4,
    parameter int RAM_ADDR_BITS   = 8,
    localparam int DATA_N_BYTES   = DATA_WIDTH / 8
)(
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       rd_read,
    input  logic [ADDR_WIDTH-1:0]      rd_address,
    input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
    input  logic [DATA_N_BYTES-1:0]    rd_byteenable,
    input  logic [USER_WIDTH-1:0]      rd_user,
    output logic                       rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      rd_readdata,
    output logic                       rd_readdatavalid,
    output logic [1:0]                 rd_response,
    output logic [USER_WIDTH-1:0]      rd_readresponseuser,

    input  logic                       wr_write,
    input  logic [ADDR_WIDTH-1:0]      wr_address,
    input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
    input  logic [DATA_WIDTH-1:0]      wr_writedata,
    input  logic [DATA_N_BYTES-1:0]    wr_byteenable,
    input  logic [USER_WIDTH-1:0]      wr_user,
    output logic                       wr_waitrequest,
    output logic                       wr_writeresponsevalid,
    output logic [1:0]                 wr_response,
    output logic [USER_WIDTH-1:0]      wr_writeresponseuser
);

    localparam int RA = RAM_ADDR_BITS;
    localparam int BC = BURST_CNT_WIDTH;

    function automatic logic [BC-1:0] eff_len(input logic [BC-1:0] bc);
        return (bc == '0) ? BC'(1) : bc;
    endfunction

    // ---------------- read channel ----------------
    t_rd_state             rd_state, rd_state_nxt;
    logic [RA-1:0]         rd_addr, rd_addr_nxt;
    logic [BC-1:0]         beats_left, beats_left_nxt;
    logic [USER_WIDTH-1:0] rd_user_q, rd_user_nxt;
    logic                  rd_accept, rd_issue, rd_wait_nxt;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign rd_accept = rd_read && !rd_waitrequest;

    always_comb begin
        rd_state_nxt   = rd_state;
        rd_addr_nxt    = rd_addr;
        beats_left_nxt = beats_left;
        rd_user_nxt    = rd_user_q;
        rd_issue       = 1'b0;
        if (rd_state == RD_BURST) begin
            rd_issue       = 1'b1;
            rd_addr_nxt    = rd_addr + RA'(1);
            beats_left_nxt = beats_left - BC'(1);
            if (beats_left == BC'(1)) rd_state_nxt = RD_IDLE;
        end
        // Only possible on the final issue cycle, which makes bursts back-to-back.
        if (rd_accept) begin
            rd_state_nxt   = RD_BURST;
            rd_addr_nxt    = rd_address[RA-1:0];
            beats_left_nxt = eff_len(rd_burstcount);
            rd_user_nxt    = rd_user;
        end
        rd_wait_nxt = (rd_state_nxt == RD_BURST) && (beats_left_nxt != BC'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state            <= RD_IDLE;
            rd_addr             <= '0;
            beats_left          <= '0;
            rd_user_q           <= '0;
            rd_waitrequest      <= 1'b1;
            rd_readdatavalid    <= 1'b0;
            rd_readresponseuser <= '0;
        end else begin
            rd_state            <= rd_state_nxt;
            rd_addr             <= rd_addr_nxt;
            beats_left          <= beats_left_nxt;
            rd_user_q           <= rd_user_nxt;
            rd_waitrequest      <= rd_wait_nxt;
            rd_readdatavalid    <= rd_issue;
            if (rd_issue) rd_readresponseuser <= rd_user_q;
        end
    end

    assign rd_readdata = ram_rd_data;
    assign rd_response = RSP_OKAY;

    // ---------------- write channel ----------------
    logic [BC-1:0]           wr_beat, wr_len, wr_len_cur;
    logic [RA-1:0]           wr_base, wr_base_cur, wr_idx;
    logic [USER_WIDTH-1:0]   wr_user_q;
    logic                    wr_first, wr_last;
    logic                    ram_wr_en;
    logic [RA-1:0]           ram_wr_addr;
    logic [DATA_WIDTH-1:0]   ram_wr_data;
    logic [DATA_N_BYTES-1:0] ram_wr_be;

    assign wr_first    = (wr_beat == '0);
    assign wr_len_cur  = wr_first ? eff_len(wr_burstcount) : wr_len;
    assign wr_base_cur = wr_first ? wr_address[RA-1:0] : wr_base;
    assign wr_idx      = wr_base_cur + RA'(wr_beat);
    assign wr_last     = (wr_beat == wr_len_cur - BC'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_beat               <= '0;
            wr_len                <= '0;
            wr_base               <= '0;
            wr_user_q             <= '0;
            ram_wr_en             <= 1'b0;
            wr_writeresponsevalid <= 1'b0;
            wr_writeresponseuser  <= '0;
        end else begin
            ram_wr_en             <= wr_write;
            wr_writeresponsevalid <= wr_write && wr_last;
            if (wr_write) begin
                if (wr_first) begin
                    wr_base   <= wr_address[RA-1:0];
                    wr_len    <= eff_len(wr_burstcount);
                    wr_user_q <= wr_user;
                end
                if (wr_last) begin
                    wr_beat              <= '0;
                    wr_writeresponseuser <= wr_first ? wr_user : wr_user_q;
                end else begin
                    wr_beat <= wr_beat + BC'(1);
                end
            end
        end
    end

    // Writes land one edge after acceptance so a read accepted on the same
    // edge, which issues one cycle later, still sees the old word.
    always_ff @(posedge clk) begin
        if (wr_write) begin
            ram_wr_addr <= wr_idx;
            ram_wr_data <= wr_writedata;
            ram_wr_be   <= wr_byteenable;
        end
    end

    assign wr_waitrequest = 1'b0;
    assign wr_response    = RSP_OKAY;

    logic unused_inputs;
    assign unused_inputs = ^{rd_byteenable, rd_address, wr_address};

    ofs_plat_avalon_mem_rdwr_sink_ram_bank #(
        .ADDR_BITS  (RA),
        .DATA_WIDTH (DATA_WIDTH)
    ) bank (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .wr_be   (ram_wr_be),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_sink_ram.sv
// Directed bench for the Avalon RAM sink: reset, single/multi-beat, byte masks, wrap, RDW, mid-burst reset.
module tb_ofs_plat_avalon_mem_rdwr_sink_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_read;
    logic [15:0] rd_address;
    logic [3:0]  rd_burstcount;
    logic [7:0]  rd_byteenable;
    logic [3:0]  rd_user;
    logic        rd_waitrequest;
    logic [63:0] rd_readdata;
    logic        rd_readdatavalid;
    logic [1:0]  rd_response;
    logic [3:0]  rd_readresponseuser;
    logic        wr_write;
    logic [15:0] wr_address;
    logic [3:0]  wr_burstcount;
    logic [63:0] wr_writedata;
    logic [7:0]  wr_byteenable;
    logic [3:0]  wr_user;
    logic        wr_waitrequest;
    logic        wr_writeresponsevalid;
    logic [1:0]  wr_response;
    logic [3:0]  wr_writeresponseuser;

    ofs_plat_avalon_mem_rdwr_sink_ram dut (
        .clk                   (clk),
        .reset                 (reset),
        .rd_read               (rd_read),
        .rd_address            (rd_address),
        .rd_burstcount         (rd_burstcount),
        .rd_byteenable         (rd_byteenable),
        .rd_user               (rd_user),
        .rd_waitrequest        (rd_waitrequest),
        .rd_readdata           (rd_readdata),
        .rd_readdatavalid      (rd_readdatavalid),
        .rd_response           (rd_response),
        .rd_readresponseuser   (rd_readresponseuser),
        .wr_write              (wr_write),
        .wr_address            (wr_address),
        .wr_burstcount         (wr_burstcount),
        .wr_writedata          (wr_writedata),
        .wr_byteenable         (wr_byteenable),
        .wr_user               (wr_user),
        .wr_waitrequest        (wr_waitrequest),
        .wr_writeresponsevalid (wr_writeresponsevalid),
        .wr_response           (wr_response),
        .wr_writeresponseuser  (wr_writeresponseuser)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Response monitor, sampled on the falling edge.
    logic [63:0] rd_q_data[$];
    logic [3:0]  rd_q_user[$];
    logic [1:0]  rd_q_resp[$];
    int          rd_q_cyc[$];
    logic [3:0]  wr_q_user[$];
    logic [1:0]  wr_q_resp[$];
    int          wr_q_cyc[$];
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (rd_readdatavalid) begin
            rd_q_data.push_back(rd_readdata);
            rd_q_user.push_back(rd_readresponseuser);
            rd_q_resp.push_back(rd_response);
            rd_q_cyc.push_back(cyc);
        end
        if (wr_writeresponsevalid) begin
            wr_q_user.push_back(wr_writeresponseuser);
            wr_q_resp.push_back(wr_response);
            wr_q_cyc.push_back(cyc);
        end
        if (rd_waitrequest && !reset) wait_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        rd_q_data.delete(); rd_q_user.delete(); rd_q_resp.delete(); rd_q_cyc.delete();
        wr_q_user.delete(); wr_q_resp.delete(); wr_q_cyc.delete();
    endtask

    task automatic wr_beat(input logic [15:0] a, input logic [3:0] bc, input logic [63:0] d,
                           input logic [7:0] be, input logic [3:0] u, output int t);
        wr_write = 1'b1; wr_address = a; wr_burstcount = bc;
        wr_writedata = d; wr_byteenable = be; wr_user = u;
        t = cyc;
        @(posedge clk); #1;
        wr_write = 1'b0;
    endtask

    task automatic rd_req(input logic [15:0] a, input logic [3:0] bc, input logic [3:0] u, output int t);
        for (int i = 0; i < 40 && rd_waitrequest; i++) begin
            @(posedge clk); #1;
        end
        check("rd_accept_ready", {63'd0, rd_waitrequest}, 64'd0);
        rd_read = 1'b1; rd_address = a; rd_burstcount = bc; rd_user = u;
        t = cyc;
        @(posedge clk); #1;
        rd_read = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        for (int i = 0; i < 40 && rd_q_data.size() < n; i++) begin
            @(posedge clk); #1;
        end
        check("rd_beat_count", 64'(rd_q_data.size()), 64'(n));
    endtask

    int t, t2;
    logic [63:0] d;

    initial begin
        reset = 1'b1;
        rd_read = 0; rd_address = 0; rd_burstcount = 0; rd_byteenable = 8'hFF; rd_user = 0;
        wr_write = 0; wr_address = 0; wr_burstcount = 0; wr_writedata = 0; wr_byteenable = 0; wr_user = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_waitrequest", {63'd0, rd_waitrequest}, 64'd1);
        check("rst_rd_valid", {63'd0, rd_readdatavalid}, 64'd0);
        check("rst_wr_rsp_valid", {63'd0, wr_writeresponsevalid}, 64'd0);
        check("rst_wr_waitrequest", {63'd0, wr_waitrequest}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_rd_waitrequest", {63'd0, rd_waitrequest}, 64'd0);

        // Single-beat write then read back with a different user.
        clear_q();
        wr_beat(16'h0005, 4'd1, 64'h1122334455667788, 8'hFF, 4'd3, t);
        repeat (3) @(posedge clk); #1;
        check("w1_rsp_count", 64'(wr_q_cyc.size()), 64'd1);
        if (wr_q_cyc.size() > 0) begin
            check("w1_rsp_cycle", 64'(wr_q_cyc[0]), 64'(t + 1));
            check("w1_rsp_user", 64'(wr_q_user[0]), 64'd3);
            check("w1_rsp_code", 64'(wr_q_resp[0]), 64'd0);
        end
        rd_req(16'h0005, 4'd1, 4'd9, t);
        wait_rd(1);
        if (rd_q_data.size() > 0) begin
            check("r1_data", rd_q_data[0], 64'h1122334455667788);
            check("r1_user", 64'(rd_q_user[0]), 64'd9);
            check("r1_cycle", 64'(rd_q_cyc[0]), 64'(t + 2));
            check("r1_resp", 64'(rd_q_resp[0]), 64'd0);
        end

        // 4-beat write; later beats carry junk address/user that must be ignored.
        clear_q();
        wr_beat(16'h0010, 4'd4, 64'hA0, 8'hFF, 4'd1, t);
        for (int b = 1; b < 4; b++) wr_beat(16'h0000, 4'd1, 64'(8'hA0 + b), 8'hFF, 4'd7, t);
        repeat (3) @(posedge clk); #1;
        check("w4_rsp_count", 64'(wr_q_cyc.size()), 64'd1);
        if (wr_q_cyc.size() > 0) begin
            check("w4_rsp_cycle", 64'(wr_q_cyc[0]), 64'(t + 1));
            check("w4_rsp_user", 64'(wr_q_user[0]), 64'd1);
        end
        wait_cnt = 0;
        rd_req(16'h0010, 4'd4, 4'd2, t);
        wait_rd(4);
        check("r4_waitrequest_cycles", 64'(wait_cnt), 64'd3);
        for (int b = 0; b < 4 && b < rd_q_data.size(); b++) begin
            check("r4_data", rd_q_data[b], 64'(8'hA0 + b));
            check("r4_cycle", 64'(rd_q_cyc[b]), 64'(t + 2 + b));
        end

        // Byte-enable merge.
        clear_q();
        wr_beat(16'h0020, 4'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'd0, t);
        wr_beat(16'h0020, 4'd1, 64'h0, 8'h0F, 4'd0, t);
        repeat (2) @(posedge clk); #1;
        check("wbe_rsp_count", 64'(wr_q_cyc.size()), 64'd2);
        rd_req(16'h0020, 4'd1, 4'd0, t);
        wait_rd(1);
        if (rd_q_data.size() > 0) check("rbe_data", rd_q_data[0], 64'hFFFFFFFF00000000);

        // Address wrap at the top of the RAM; upper address bits are ignored.
        clear_q();
        wr_beat(16'h00FF, 4'd2, 64'hB0, 8'hFF, 4'd2, t);
        wr_beat(16'h0000, 4'd2, 64'hB1, 8'hFF, 4'd2, t);
        repeat (2) @(posedge clk); #1;
        rd_req(16'h0100, 4'd1, 4'd0, t);
        wait_rd(1);
        if (rd_q_data.size() > 0) check("wrap_word0", rd_q_data[0], 64'hB1);
        clear_q();
        rd_req(16'h00FF, 4'd2, 4'd4, t);
        wait_rd(2);
        if (rd_q_data.size() > 1) begin
            check("wrap_rd_beat0", rd_q_data[0], 64'hB0);
            check("wrap_rd_beat1", rd_q_data[1], 64'hB1);
            check("wrap_rd_user", 64'(rd_q_user[1]), 64'd4);
        end

        // Read and write of the same word accepted on the same edge.
        clear_q();
        wr_beat(16'h0030, 4'd1, 64'h1111, 8'hFF, 4'd0, t);
        repeat (2) @(posedge clk); #1;
        rd_read = 1'b1; rd_address = 16'h0030; rd_burstcount = 4'd1; rd_user = 4'd5;
        wr_write = 1'b1; wr_address = 16'h0030; wr_burstcount = 4'd1;
        wr_writedata = 64'h2222; wr_byteenable = 8'hFF; wr_user = 4'd6;
        t = cyc;
        @(posedge clk); #1;
        rd_read = 1'b0; wr_write = 1'b0;
        clear_q();
        wait_rd(1);
        if (rd_q_data.size() > 0) begin
            check("rdw_old_data", rd_q_data[0], 64'h1111);
            check("rdw_cycle", 64'(rd_q_cyc[0]), 64'(t + 2));
        end
        clear_q();
        rd_req(16'h0030, 4'd0, 4'd0, t2);
        wait_rd(1);
        if (rd_q_data.size() > 0) check("rdw_new_data", rd_q_data[0], 64'h2222);

        // Reset during beat 2 of an 8-beat read.
        clear_q();
        rd_req(16'h0010, 4'd8, 4'd1, t);
        for (int i = 0; i < 20 && rd_q_data.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_beats_seen", 64'(rd_q_data.size()), 64'd2);
        reset = 1'b1;
        #1;
        check("rst_mid_waitrequest", {63'd0, rd_waitrequest}, 64'd1);
        check("rst_mid_valid", {63'd0, rd_readdatavalid}, 64'd0);
        clear_q();
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_rel_waitrequest", {63'd0, rd_waitrequest}, 64'd0);
        repeat (10) @(posedge clk); #1;
        check("rst_mid_no_beats", 64'(rd_q_data.size()), 64'd0);
        rd_req(16'h0005, 4'd1, 4'd8, t);
        wait_rd(1);
        if (rd_q_data.size() > 0) begin
            d = rd_q_data[0];
            check("rst_after_data", d, 64'h1122334455667788);
            check("rst_after_cycle", 64'(rd_q_cyc[0]), 64'(t + 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
